// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter and its MDU hold buffer.
package grf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2
  } arb_gnt_e;

  localparam int         STARVE_LIMIT_DEF = 4;
  localparam int         DATA_W           = 32;
  localparam int         RW_W             = 5;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  // A write to r0 is architecturally a no-op, so it never counts as a request.
  function automatic logic is_real_write(input logic we, input logic [RW_W-1:0] rw);
    return we && (rw != REG_ZERO);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/grf_md_skid.sv
// One-entry hold register for a pending MDU write-back (valid + rw/data/pc payload).
module grf_md_skid
  import grf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [RW_W-1:0]   in_rw,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_pc,
  output logic              valid,
  output logic [RW_W-1:0]   rw,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] pc
);

  logic              valid_d, valid_q;
  logic [RW_W-1:0]   rw_d, rw_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] pc_d, pc_q;

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      rw_d    = in_rw;
      data_d  = in_data;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is only meaningful while valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    rw_q   <= rw_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  assign valid = valid_q;
  assign rw    = rw_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the WB stage and a buffered MDU result,
// stalling the pipeline for one cycle when the MDU entry has been starved too long.
module grf_wb_arbiter
  import grf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_rw,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  output logic        grf_we,
  output logic [4:0]  grf_rw,
  output logic [31:0] grf_busW,
  output logic [31:0] grf_pc,
  output logic        stall_pipe,
  output logic        md_pending,
  output logic [4:0]  md_pending_rw
);

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  arb_state_e  state_d, state_q;
  logic [3:0]  wait_cnt_d, wait_cnt_q;
  logic [4:0]  wait_cnt_inc;
  arb_gnt_e    gnt;

  logic        wb_real;
  logic        hold_load, hold_clear;
  logic        hold_valid;
  logic [4:0]  hold_rw;
  logic [31:0] hold_data, hold_pc;

  assign wb_real      = is_real_write(wb_we, wb_rw);
  assign md_ready     = !hold_valid;
  // r0 results are handshaken away but never occupy the buffer.
  assign hold_load    = md_valid && md_ready && (md_rw != REG_ZERO);
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 5'd1;

  grf_md_skid u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .in_rw   (md_rw),
    .in_data (md_data),
    .in_pc   (md_pc),
    .valid   (hold_valid),
    .rw      (hold_rw),
    .data    (hold_data),
    .pc      (hold_pc)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = GNT_NONE;
    hold_clear = 1'b0;
    case (state_q)
      ST_FORCE: begin
        gnt        = GNT_MD;
        hold_clear = 1'b1;
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
      default: begin
        if (wb_real) begin
          gnt = GNT_WB;
          if (hold_valid) begin
            wait_cnt_d = sat_inc4(wait_cnt_q);
            state_d    = (wait_cnt_inc >= LIMIT) ? ST_FORCE : ST_WAIT;
          end
        end else if (hold_valid) begin
          gnt        = GNT_MD;
          hold_clear = 1'b1;
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    grf_we   = 1'b0;
    grf_rw   = 5'd0;
    grf_busW = 32'd0;
    grf_pc   = 32'd0;
    case (gnt)
      GNT_WB: begin
        grf_we   = 1'b1;
        grf_rw   = wb_rw;
        grf_busW = wb_data;
        grf_pc   = wb_pc;
      end
      GNT_MD: begin
        grf_we   = 1'b1;
        grf_rw   = hold_rw;
        grf_busW = hold_data;
        grf_pc   = hold_pc;
      end
      default: ;
    endcase
  end

  assign stall_pipe    = (state_q == ST_FORCE);
  assign md_pending    = hold_valid;
  assign md_pending_rw = hold_valid ? hold_rw : 5'd0;

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost slots before the pipeline is forced to stall (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports wb_we  in  1, wb_rw  in  5, wb_data  in  32, wb_pc  in  32: pipeline WB-stage write request, no backpressure.
REQ-005 SHALL have ports md_valid  in  1, md_rw  in  5, md_data  in  32, md_pc  in  32: mult/div unit result request.
REQ-006 SHALL have port md_ready  out  1: MDU result accepted at the edge where md_valid && md_ready.
REQ-007 SHALL have ports grf_we  out  1, grf_rw  out  5, grf_busW  out  32, grf_pc  out  32: single GRF write port, plus the PC used for the trace print.
REQ-008 SHALL have port stall_pipe  out  1: when high, the WB stage holds its instruction and re-presents it next cycle.
REQ-009 SHALL have ports md_pending  out  1, md_pending_rw  out  5: buffered MDU write not yet committed, for the hazard unit.

Function
REQ-010 SHALL treat a write request to register 0 as no request; wb_we with wb_rw==0 frees the slot.
REQ-011 SHALL accept MDU results into a 1-entry hold buffer; md_ready = !hold_valid; MDU results to register 0 are accepted and discarded, never buffered.
REQ-012 SHALL drive grf_* combinationally from the current mux choice: zero added latency for WB; an MDU result accepted at edge E reaches the GRF no earlier than edge E+1.
REQ-013 SHALL implement states IDLE (hold empty), WAIT (hold full, slot lost at least once), FORCE (hold full, pipeline stalled).
REQ-014 SHALL grant, with hold full and state != FORCE: WB if it has a real write; otherwise the hold entry.
REQ-015 SHALL transition IDLE/WAIT -> IDLE when the hold drains without new capture; -> WAIT when WB wins and wait_cnt+1 < STARVE_LIMIT; -> FORCE when WB wins and wait_cnt+1 == STARVE_LIMIT.
REQ-016 SHALL in FORCE drive stall_pipe=1 (Moore), ignore wb_* that cycle, write the hold entry, and return to IDLE.
REQ-017 SHALL keep a 4-bit wait_cnt: +1 per slot lost by the hold entry, cleared when the hold drains; it never wraps.
REQ-018 SHALL drive grf_we=0 and grf_rw/grf_busW/grf_pc=0 when nothing is granted.
REQ-019 SHALL drive md_pending=hold_valid and md_pending_rw=hold rw (0 when empty); same-register WB/MDU ordering is resolved by the hazard unit, not here.
REQ-020 SHALL let the hold accept a new MDU result only in a cycle after it has drained; throughput is at most 1 MDU write per 2 cycles.

Reset
REQ-021 SHALL on reset low, immediately and without clk: state=IDLE, hold_valid=0, wait_cnt=0, stall_pipe=0, md_ready=1, md_pending=0, md_pending_rw=0.
REQ-022 SHALL drop any buffered MDU write when reset is asserted mid-operation; the GRF is not written for it.
REQ-023 SHALL leave grf_we following only wb_* after reset release (state IDLE).

Structure
REQ-024 SHALL place the state encoding (IDLE/WAIT/FORCE), the STARVE_LIMIT default and the REG_ZERO constant in shared package grf_arb_pkg.
REQ-025 SHALL implement the hold buffer as sub-module grf_md_skid (valid/data/rw/pc register with load/clear), instantiated once.

Verification
REQ-026 SHALL cover: wb_we=1, rw=5, data=0x1234 with MDU idle -> grf_we=1, rw=5, busW=0x1234 in the same cycle; md_ready stays 1.
REQ-027 SHALL cover: md_valid, rw=8, data=0xABCD accepted at edge E with wb_we=0 -> md_pending=1 after E; grf write of rw=8 in cycle E..E+1; md_pending=0 after E+1.
REQ-028 SHALL cover: MDU result held and wb_we=1 (rw!=0) for 4 cycles with STARVE_LIMIT=4 -> WB wins 4 cycles, then stall_pipe=1 for exactly 1 cycle with the MDU write granted, then IDLE.
REQ-029 SHALL cover: md_rw=0 accepted -> no md_pending, no grf write; wb_we=1 with rw=0 -> grf_we=0 and a held MDU entry drains that cycle.
REQ-030 SHALL cover: reset low while state=WAIT with hold full -> all outputs at reset values at once; the held write never appears on grf_we.
